// File: rtl/ring_switch_pkg.sv
// ring_switch_pkg: shared constants and helpers for the N-port ring switch.
//   DEF_*      default parameter values for ring_switch_n
//   MAX_PORTS  largest supported port count (width of mask_of's result)
//   mask_of    destination mask carried in the low bits of a packet
//   hops       ring distance from a source node to a destination node
package ring_switch_pkg;

    localparam int DEF_NUM_PORTS = 4;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_IN_DEPTH  = 4;
    localparam int DEF_OUT_DEPTH = 4;
    localparam int DEF_CNT_W     = 32;
    localparam int MAX_PORTS     = 16;

    // Keeps only the low nports bits; callers pass the packet's low MAX_PORTS bits.
    function automatic logic [MAX_PORTS-1:0] mask_of(input logic [MAX_PORTS-1:0] data,
                                                     input int nports);
        logic [MAX_PORTS-1:0] keep;
        keep = '0;
        for (int i = 0; i < MAX_PORTS; i++) keep[i] = (i < nports);
        return data & keep;
    endfunction

    // Packets travel from node k+1 to node k, so the distance counts downwards.
    function automatic int hops(input int src, input int dst, input int nports);
        return (src - dst + nports) % nports;
    endfunction

endpackage

// File: rtl/ring_switch_n_fifo.sv
// switch_fifo: single-clock synchronous FIFO used for both ingress and egress queues.
//   clk, reset      clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data write request; ignored while full
//   pop, pop_data   read request; pop_data shows the head combinationally
//   full, empty     status derived from count
//   count           current occupancy (0..DEPTH)
module switch_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push, do_pop;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ring_switch_n.sv
// ring_switch_n: N-port unidirectional ring packet switch with multicast.
// Each node owns an input FIFO, a ring slot and an output FIFO. A packet's low
// NUM_PORTS bits are its destination mask; it circulates (node k+1 -> node k)
// until every destination has taken a copy. Ring traffic beats injection.
//   clk, reset        clock, asynchronous active-low reset
//   in_valid/in_data  per-port ingress; port p at in_data[p*DATA_W +: DATA_W]
//   in_suspend        input FIFO p full (combinational)
//   out_valid/out_data registered egress, out_data holds when idle
//   out_suspend       downstream backpressure per port
//   pkts_in/pkts_out/pkts_dropped  statistics counters (wrap)
// Macro RING_SWITCH_STATS_EN builds the counters; otherwise they read 0.
module ring_switch_n
    import ring_switch_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int IN_DEPTH  = DEF_IN_DEPTH,
    parameter int OUT_DEPTH = DEF_OUT_DEPTH,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        in_valid,
    input  logic [NUM_PORTS*DATA_W-1:0] in_data,
    output logic [NUM_PORTS-1:0]        in_suspend,
    output logic [NUM_PORTS-1:0]        out_valid,
    output logic [NUM_PORTS*DATA_W-1:0] out_data,
    input  logic [NUM_PORTS-1:0]        out_suspend,
    output logic [CNT_W-1:0]            pkts_in,
    output logic [CNT_W-1:0]            pkts_out,
    output logic [CNT_W-1:0]            pkts_dropped
);
    localparam int ICW = $clog2(IN_DEPTH + 1);
    localparam int OCW = $clog2(OUT_DEPTH + 1);

    typedef struct packed {
        logic                 valid;
        logic [DATA_W-1:0]    data;
        logic [NUM_PORTS-1:0] pend;   // destinations still owed a copy
    } slot_t;

    slot_t [NUM_PORTS-1:0]             slot_q, upd, slot_d;
    logic  [NUM_PORTS-1:0][DATA_W-1:0] in_pkt, in_head, out_head, out_q;
    logic  [NUM_PORTS-1:0][ICW-1:0]    in_count;
    logic  [NUM_PORTS-1:0][OCW-1:0]    out_count;
    logic  [NUM_PORTS-1:0]             in_full, in_empty, in_pop, accept;
    logic  [NUM_PORTS-1:0]             out_full, out_empty, out_pop, deliver;
    logic  [NUM_PORTS-1:0]             out_valid_q;
    logic                              unused_fifo;

    assign unused_fifo = ^{in_full, out_count};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        localparam int                   NXT = (p + 1) % NUM_PORTS;
        localparam logic [NUM_PORTS-1:0] OWN = NUM_PORTS'(1) << p;

        logic [NUM_PORTS-1:0] pkt_mask, head_mask;
        logic                 fwd;

        // Ingress: full is judged on the occupancy at the start of the cycle.
        assign in_pkt[p]     = in_data[p*DATA_W +: DATA_W];
        assign pkt_mask      = NUM_PORTS'(mask_of(MAX_PORTS'(in_pkt[p]), NUM_PORTS));
        assign head_mask     = NUM_PORTS'(mask_of(MAX_PORTS'(in_head[p]), NUM_PORTS));
        assign in_suspend[p] = (in_count[p] == ICW'(IN_DEPTH));
        assign accept[p]     = in_valid[p] && !in_suspend[p] && (pkt_mask != '0);

        // Delivery at this node; a blocked copy keeps its bit and goes round again.
        assign deliver[p]    = slot_q[p].valid && slot_q[p].pend[p] && !out_full[p];
        assign upd[p].valid  = slot_q[p].valid;
        assign upd[p].data   = slot_q[p].data;
        assign upd[p].pend   = deliver[p] ? (slot_q[p].pend & ~OWN) : slot_q[p].pend;

        // Shift: a packet still owed copies wins over a new injection.
        assign fwd       = upd[NXT].valid && (upd[NXT].pend != '0);
        assign in_pop[p] = !fwd && !in_empty[p];
        assign slot_d[p] = fwd       ? upd[NXT]
                         : in_pop[p] ? slot_t'{1'b1, in_head[p], head_mask}
                         :             slot_t'('0);

        assign out_pop[p] = !out_empty[p] && !out_suspend[p];
        assign out_data[p*DATA_W +: DATA_W] = out_q[p];

        switch_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (accept[p]),
            .push_data (in_pkt[p]),
            .pop       (in_pop[p]),
            .pop_data  (in_head[p]),
            .full      (in_full[p]),
            .empty     (in_empty[p]),
            .count     (in_count[p])
        );

        switch_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (deliver[p]),
            .push_data (slot_q[p].data),
            .pop       (out_pop[p]),
            .pop_data  (out_head[p]),
            .full      (out_full[p]),
            .empty     (out_empty[p]),
            .count     (out_count[p])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q      <= '0;
            out_valid_q <= '0;
            out_q       <= '0;
        end else begin
            slot_q      <= slot_d;
            out_valid_q <= out_pop;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (out_pop[p]) out_q[p] <= out_head[p];
            end
        end
    end

    assign out_valid = out_valid_q;

`ifdef RING_SWITCH_STATS_EN
    localparam int SW = $clog2(NUM_PORTS + 1);

    logic [SW-1:0]    n_in, n_out, n_drop;
    logic [CNT_W-1:0] cnt_in, cnt_out, cnt_drop;

    // Several ports can accept, drop or deliver in the same cycle.
    always_comb begin
        n_in   = '0;
        n_out  = '0;
        n_drop = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            n_in   = n_in   + SW'(accept[p]);
            n_out  = n_out  + SW'(out_pop[p]);
            n_drop = n_drop + SW'(in_valid[p] && !accept[p]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_in   <= '0;
            cnt_out  <= '0;
            cnt_drop <= '0;
        end else begin
            cnt_in   <= cnt_in   + CNT_W'(n_in);
            cnt_out  <= cnt_out  + CNT_W'(n_out);
            cnt_drop <= cnt_drop + CNT_W'(n_drop);
        end
    end

    assign pkts_in      = cnt_in;
    assign pkts_out     = cnt_out;
    assign pkts_dropped = cnt_drop;
`else
    assign pkts_in      = '0;
    assign pkts_out     = '0;
    assign pkts_dropped = '0;
`endif

endmodule
